// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared encodings and sizing helpers for the ID-stage hazard scoreboard.
package id_hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MUL  = 2'd2,
        LAT_RSVD = 2'd3
    } lat_class_e;

    typedef enum logic [1:0] {
        STAGE_REGFILE = 2'd0,
        STAGE_EX      = 2'd1,
        STAGE_MEM     = 2'd2,
        STAGE_WB      = 2'd3
    } stage_e;

    // Width of a stage index able to name 0..nstage.
    function automatic int unsigned sel_width(input int unsigned nstage);
        return $clog2(nstage + 1);
    endfunction

    // Age at which a producer of the given class can be forwarded; reserved acts as ALU.
    function automatic int unsigned ready_age(input lat_class_e cls,
                                              input int unsigned ld_lat,
                                              input int unsigned mul_lat);
        case (cls)
            LAT_LOAD: return ld_lat;
            LAT_MUL:  return mul_lat;
            default:  return 1;
        endcase
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// Issue-side bundle between the decode stage and the hazard scoreboard.
interface id_hazard_scoreboard_if
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned AW     = 5,
    parameter int unsigned NSTAGE = 3
);
    localparam int unsigned SW = sel_width(NSTAGE);

    logic          issue_valid;
    logic          pipe_adv;
    logic          flush;
    logic          rs_en;
    logic [AW-1:0] rs;
    logic          rt_en;
    logic [AW-1:0] rt;
    logic          rd_we;
    logic [AW-1:0] rd;
    logic [1:0]    lat_class;
    logic          stall_req;
    logic          issue_fire;
    logic [SW-1:0] fwd_sel_rs;
    logic [SW-1:0] fwd_sel_rt;
    logic [31:0]   stall_cnt;

    modport master (
        output issue_valid, pipe_adv, flush, rs_en, rs, rt_en, rt, rd_we, rd, lat_class,
        input  stall_req, issue_fire, fwd_sel_rs, fwd_sel_rt, stall_cnt
    );

    modport slave (
        input  issue_valid, pipe_adv, flush, rs_en, rs, rt_en, rt, rd_we, rd, lat_class,
        output stall_req, issue_fire, fwd_sel_rs, fwd_sel_rt, stall_cnt
    );

endinterface

// File: rtl/id_hazard_scoreboard_sb_entry.sv
// One architectural register's in-flight producer: busy flag, pipeline age and ready age.
module id_hazard_scoreboard_sb_entry
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned SW     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic [SW-1:0] set_rdy,
    input  logic          adv,
    input  logic          flush,
    output logic          busy,
    output logic [SW-1:0] age,
    output logic [SW-1:0] rdy
);

    // A new writer overrides any older one; flush only kills a producer still in EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            age  <= '0;
            rdy  <= '0;
        end else if (set) begin
            busy <= 1'b1;
            age  <= SW'(STAGE_EX);
            rdy  <= set_rdy;
        end else if (busy && flush && (age == SW'(STAGE_EX))) begin
            busy <= 1'b0;
            age  <= '0;
            rdy  <= '0;
        end else if (busy && adv) begin
            if (age == SW'(NSTAGE)) begin
                busy <= 1'b0;
                age  <= '0;
                rdy  <= '0;
            end else begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage RAW hazard detection and forwarding-source selection over per-register producer state.
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned AW      = 5,
    parameter int unsigned NSTAGE  = 3,
    parameter int unsigned LD_LAT  = 2,
    parameter int unsigned MUL_LAT = 3
) (
    input logic                   clk,
    input logic                   rst,
    id_hazard_scoreboard_if.slave sb
);

    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned SW   = sel_width(NSTAGE);

    if (LD_LAT > NSTAGE || MUL_LAT > NSTAGE || LD_LAT == 0 || MUL_LAT == 0) begin : g_bad_cfg
        $error("id_hazard_scoreboard: LD_LAT/MUL_LAT must lie in 1..NSTAGE");
    end

    logic [NREG-1:0] busy;
    logic [SW-1:0]   age [NREG];
    logic [SW-1:0]   rdy [NREG];
    logic            set_any;
    logic [SW-1:0]   set_rdy;
    logic            hz_rs;
    logic            hz_rt;
    logic [31:0]     cnt;

    // r0 is hardwired and never tracked.
    assign busy[0] = 1'b0;
    assign age[0]  = '0;
    assign rdy[0]  = '0;

    assign set_rdy = SW'(ready_age(lat_class_e'(sb.lat_class), LD_LAT, MUL_LAT));
    assign set_any = sb.issue_fire && sb.rd_we && (sb.rd != '0) && !sb.flush;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        id_hazard_scoreboard_sb_entry #(
            .NSTAGE (NSTAGE),
            .SW     (SW)
        ) u_sb_entry (
            .clk     (clk),
            .rst     (rst),
            .set     (set_any && (sb.rd == AW'(r))),
            .set_rdy (set_rdy),
            .adv     (sb.pipe_adv),
            .flush   (sb.flush),
            .busy    (busy[r]),
            .age     (age[r]),
            .rdy     (rdy[r])
        );
    end

    // A producer younger than its ready age cannot be forwarded yet.
    always_comb begin
        hz_rs         = sb.rs_en && busy[sb.rs] && (age[sb.rs] < rdy[sb.rs]);
        hz_rt         = sb.rt_en && busy[sb.rt] && (age[sb.rt] < rdy[sb.rt]);
        sb.fwd_sel_rs = SW'(STAGE_REGFILE);
        sb.fwd_sel_rt = SW'(STAGE_REGFILE);
        if (sb.rs_en && busy[sb.rs] && !hz_rs) sb.fwd_sel_rs = age[sb.rs];
        if (sb.rt_en && busy[sb.rt] && !hz_rt) sb.fwd_sel_rt = age[sb.rt];
    end

    assign sb.stall_req  = sb.issue_valid && (hz_rs || hz_rt);
    assign sb.issue_fire = sb.issue_valid && sb.pipe_adv && !sb.stall_req && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (sb.stall_req && (cnt != '1)) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign sb.stall_cnt = cnt;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed vector table plus randomized traffic against a pipeline-slot reference model.
module tb_id_hazard_scoreboard;
    import id_hazard_scoreboard_pkg::*;

    localparam int unsigned AW      = 5;
    localparam int unsigned NSTAGE  = 3;
    localparam int unsigned LD_LAT  = 2;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned SW      = sel_width(NSTAGE);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_hazard_scoreboard_if #(.AW(AW), .NSTAGE(NSTAGE)) sbif ();

    id_hazard_scoreboard #(
        .AW(AW), .NSTAGE(NSTAGE), .LD_LAT(LD_LAT), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif)
    );

    typedef struct {
        logic          rst;
        logic          iv;
        logic          adv;
        logic          fl;
        logic          rs_en;
        logic [AW-1:0] rs;
        logic          rt_en;
        logic [AW-1:0] rt;
        logic          rd_we;
        logic [AW-1:0] rd;
        logic [1:0]    cls;
        logic          e_stall;
        logic          e_fire;
        logic [SW-1:0] e_fr;
        logic [SW-1:0] e_ft;
        logic [31:0]   e_cnt;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one slot per stage after ID, holding the tracked producer there.
    bit          m_v   [1:NSTAGE];
    int unsigned m_rd  [1:NSTAGE];
    int unsigned m_rdy [1:NSTAGE];
    logic [31:0] m_cnt;

    function automatic vec_t mk(input int r, iv, adv, fl, rse, rs, rte, rt, we, rd, cls,
                                input int es, ef, efr, eft, ecnt);
        vec_t v;
        v.rst = 1'(r);   v.iv = 1'(iv);    v.adv = 1'(adv);  v.fl = 1'(fl);
        v.rs_en = 1'(rse); v.rs = AW'(rs); v.rt_en = 1'(rte); v.rt = AW'(rt);
        v.rd_we = 1'(we);  v.rd = AW'(rd); v.cls = 2'(cls);
        v.e_stall = 1'(es); v.e_fire = 1'(ef);
        v.e_fr = SW'(efr);  v.e_ft = SW'(eft); v.e_cnt = 32'(ecnt);
        return v;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        rst              = v.rst;
        sbif.issue_valid = v.iv;
        sbif.pipe_adv    = v.adv;
        sbif.flush       = v.fl;
        sbif.rs_en       = v.rs_en;
        sbif.rs          = v.rs;
        sbif.rt_en       = v.rt_en;
        sbif.rt          = v.rt;
        sbif.rd_we       = v.rd_we;
        sbif.rd          = v.rd;
        sbif.lat_class   = v.cls;
        @(negedge clk);
        check({tag, ".stall_req"},  longint'(sbif.stall_req),  longint'(v.e_stall));
        check({tag, ".issue_fire"}, longint'(sbif.issue_fire), longint'(v.e_fire));
        check({tag, ".fwd_sel_rs"}, longint'(sbif.fwd_sel_rs), longint'(v.e_fr));
        check({tag, ".fwd_sel_rt"}, longint'(sbif.fwd_sel_rt), longint'(v.e_ft));
        check({tag, ".stall_cnt"},  longint'(sbif.stall_cnt),  longint'(v.e_cnt));
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned class_ready(input logic [1:0] cls);
        if (cls == 2'd1) return LD_LAT;
        if (cls == 2'd2) return MUL_LAT;
        return 1;
    endfunction

    function automatic void model_src(input logic en, input logic [AW-1:0] r,
                                      output logic hz, output logic [SW-1:0] fwd);
        hz  = 1'b0;
        fwd = '0;
        if (en) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                if (m_v[k] && m_rd[k] == int'(r)) begin
                    if (k < int'(m_rdy[k])) hz = 1'b1;
                    else fwd = SW'(k);
                end
            end
        end
    endfunction

    function automatic void model_expect(inout vec_t v);
        logic hs, ht;
        logic [SW-1:0] fs, ft;
        model_src(v.rs_en, v.rs, hs, fs);
        model_src(v.rt_en, v.rt, ht, ft);
        v.e_stall = v.iv && (hs || ht);
        v.e_fire  = v.iv && v.adv && !v.e_stall && !v.rst;
        v.e_fr    = fs;
        v.e_ft    = ft;
        v.e_cnt   = m_cnt;
    endfunction

    function automatic void model_update(input vec_t v);
        bit set;
        if (v.rst) begin
            for (int k = 1; k <= NSTAGE; k++) m_v[k] = 1'b0;
            m_cnt = '0;
            return;
        end
        if (v.e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        set = v.e_fire && v.rd_we && (v.rd != 0) && !v.fl;
        if (v.fl) m_v[1] = 1'b0;
        // The youngest writer of a register hides every older one.
        if (set) begin
            for (int k = 1; k <= NSTAGE; k++)
                if (m_v[k] && m_rd[k] == int'(v.rd)) m_v[k] = 1'b0;
        end
        if (v.adv) begin
            for (int k = NSTAGE; k >= 2; k--) begin
                m_v[k]   = m_v[k-1];
                m_rd[k]  = m_rd[k-1];
                m_rdy[k] = m_rdy[k-1];
            end
            m_v[1]   = set;
            m_rd[1]  = int'(v.rd);
            m_rdy[1] = class_ready(v.cls);
        end
    endfunction

    vec_t tbl[$];

    initial begin
        // rst iv adv fl | rse rs rte rt | we rd cls | stall fire fr ft cnt
        tbl.push_back(mk(0,1,1,0, 0,0,0,0, 1,5,0, 0,1,0,0,0)); // ALU r5
        tbl.push_back(mk(0,1,1,0, 1,5,0,0, 0,0,0, 0,1,1,0,0));
        tbl.push_back(mk(0,1,1,0, 1,5,0,0, 0,0,0, 0,1,2,0,0));
        tbl.push_back(mk(0,1,1,0, 1,5,0,0, 0,0,0, 0,1,3,0,0));
        tbl.push_back(mk(0,1,1,0, 1,5,0,0, 0,0,0, 0,1,0,0,0)); // r5 retired
        tbl.push_back(mk(0,1,1,0, 0,0,0,0, 1,8,1, 0,1,0,0,0)); // LOAD r8
        tbl.push_back(mk(0,1,1,0, 0,0,1,8, 0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,0, 0,0,1,8, 0,0,0, 0,1,0,2,1));
        tbl.push_back(mk(0,1,1,0, 0,0,0,0, 1,4,1, 0,1,0,0,1)); // LOAD r4
        tbl.push_back(mk(0,1,1,0, 0,0,0,0, 1,4,0, 0,1,0,0,1)); // ALU r4
        tbl.push_back(mk(0,1,1,0, 1,4,1,4, 0,0,0, 0,1,1,1,1));
        tbl.push_back(mk(0,1,1,0, 0,0,0,0, 1,7,0, 0,1,0,0,1)); // ALU r7
        tbl.push_back(mk(0,0,1,1, 0,0,0,0, 0,0,0, 0,0,0,0,1)); // flush
        tbl.push_back(mk(0,1,1,0, 1,7,0,0, 0,0,0, 0,1,0,0,1));
        tbl.push_back(mk(0,1,1,0, 0,0,0,0, 1,0,0, 0,1,0,0,1)); // write r0
        tbl.push_back(mk(0,1,1,0, 1,0,1,0, 0,0,0, 0,1,0,0,1));
        tbl.push_back(mk(0,1,1,0, 0,0,0,0, 1,9,1, 0,1,0,0,1)); // LOAD r9
        tbl.push_back(mk(0,1,1,0, 1,9,1,9, 0,0,0, 1,0,0,0,1));
        tbl.push_back(mk(0,1,1,0, 1,9,1,9, 0,0,0, 0,1,2,2,2));

        rst = 1'b1;
        apply(mk(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0), "rst_hold");
        apply(mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0), "reset_state");

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // MUL r3 with a 4-cycle freeze while the reader stalls.
        apply(mk(1,0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0,2), "mul.rst");
        apply(mk(0,1,1,0, 0,0,0,0, 1,3,2, 0,1,0,0,0), "mul.issue");
        apply(mk(0,1,1,0, 1,3,0,0, 0,0,0, 1,0,0,0,0), "mul.s1");
        for (int i = 0; i < 4; i++)
            apply(mk(0,1,0,0, 1,3,0,0, 1,10,0, 1,0,0,0,i+1), $sformatf("mul.frz%0d", i));
        apply(mk(0,1,1,0, 1,3,0,0, 0,0,0, 1,0,0,0,5), "mul.s2");
        apply(mk(0,1,1,0, 1,3,0,0, 0,0,0, 0,1,3,0,6), "mul.fwd");
        apply(mk(0,1,1,0, 1,3,1,10, 0,0,0, 0,1,0,0,6), "mul.after");

        // Reset with three producers in flight.
        apply(mk(0,1,1,0, 0,0,0,0, 1,1,0, 0,1,0,0,6), "rip.alu");
        apply(mk(0,1,1,0, 0,0,0,0, 1,2,1, 0,1,0,0,6), "rip.load");
        apply(mk(0,1,1,0, 0,0,0,0, 1,3,2, 0,1,0,0,6), "rip.mul");
        apply(mk(0,1,1,0, 1,3,0,0, 0,0,0, 1,0,0,0,6), "rip.stall");
        apply(mk(1,1,1,0, 0,0,0,0, 1,6,0, 0,0,0,0,7), "rip.rst");
        apply(mk(0,1,1,0, 1,2,1,3, 0,0,0, 0,1,0,0,0), "rip.clean");
        apply(mk(0,1,1,0, 1,1,1,6, 0,0,0, 0,1,0,0,0), "rip.clean2");

        // Randomized traffic over a small register window to provoke hazards.
        begin
            vec_t v;
            v = mk(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0);
            m_cnt = 32'd0;
            for (int k = 1; k <= NSTAGE; k++) m_v[k] = 1'b0;
            model_expect(v);
            v.e_stall = 1'b0;
            v.e_cnt   = sbif.stall_cnt;
            rst = 1'b1;
            sbif.issue_valid = 1'b0;
            @(posedge clk);
            #1;
            model_update(v);
            for (int i = 0; i < 2000; i++) begin
                v.rst   = ($urandom_range(99) == 0);
                v.iv    = ($urandom_range(3) != 0);
                v.adv   = ($urandom_range(9) < 8);
                v.fl    = ($urandom_range(9) == 0);
                v.rs_en = 1'($urandom_range(1));
                v.rs    = AW'($urandom_range(7));
                v.rt_en = 1'($urandom_range(1));
                v.rt    = AW'($urandom_range(7));
                v.rd_we = ($urandom_range(3) != 0);
                v.rd    = AW'($urandom_range(7));
                v.cls   = 2'($urandom_range(3));
                model_expect(v);
                apply(v, $sformatf("rnd%0d", i));
                model_update(v);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
